// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
//   rx_state_e  : receiver FSM states
//   OVERSAMPLE  : oversample ticks per serial bit
//   FIFO_DEPTH  : receive FIFO entries
//   calc_div    : clocks per oversample tick, truncated, never below 1
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned div;
    div = clk_hz / (baud * OVERSAMPLE);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator.
//   clk   : system clock
//   reset : synchronous active-high reset
//   tick  : one-cycle pulse every CLK_HZ/(BAUD*16) clocks
// The counter is never realigned to the serial data; the receiver absorbs the
// phase error with its mid-bit sampling.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned Div  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == DivLast);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver with a 4-entry first-word-fall-through FIFO.
//   clk           : system clock, all logic on its rising edge
//   reset         : synchronous active-high reset
//   uartRx        : asynchronous serial input, idle high, LSB first
//   rdEn          : pop strobe, ignored while empty
//   dataOut       : FIFO head byte, 0x00 while empty
//   dataAvailable : FIFO not empty
//   frameError    : one-cycle pulse when the stop bit is sampled low
//   overrun       : one-cycle pulse when a byte completes with the FIFO full
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uartRx,
  input  logic       rdEn,
  output logic [7:0] dataOut,
  output logic       dataAvailable,
  output logic       frameError,
  output logic       overrun
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MidTick  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] FifoFull = 3'(FIFO_DEPTH);

  // Input synchronizer; idle-high reset so reset never looks like a start bit.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uartRx;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic tick;

  baud_tick_gen #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Receiver FSM
  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       push;
  logic       frame_error_q, frame_error_d;

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (tick && !rx_sync_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end

      // Confirm the start bit half a bit later; a high line there is a glitch.
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == MidTick) begin
            tick_cnt_d = '0;
            if (!rx_sync_q) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      // Sampling points now sit near the middle of each data bit.
      StData: begin
        if (tick) begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            state_d    = StIdle;
            if (rx_sync_q) begin
              push = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Receive FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            pop, full, wr_en;

  always_comb begin
    pop   = rdEn && (count_q != 3'd0);
    full  = (count_q == FifoFull);
    // A simultaneous pop frees the slot, so a push at full still lands.
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_comb begin
    dataAvailable = (count_q != 3'd0);
    dataOut       = dataAvailable ? mem_q[rd_ptr_q] : 8'h00;
    frameError    = frame_error_q;
    overrun       = overrun_q;
  end

endmodule
